// File: rtl/scr1_dmem_router_np_pkg.sv
// Shared types, select encoding and address decode for the SCR1 DMEM N-port router.
package scr1_dmem_router_pkg;

  typedef enum logic [1:0] {
    SCR1_MEM_CMD_RD    = 2'b00,
    SCR1_MEM_CMD_WR    = 2'b01,
    SCR1_MEM_CMD_ERROR = 2'b11
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10,
    SCR1_MEM_RESP_ERROR  = 2'b11
  } type_scr1_mem_resp_e;

  // Select code is sized for the largest supported port count so every instance shares it.
  localparam int MAX_PORTS = 8;
  localparam int MAX_DEPTH = 4;
  localparam int SEL_W     = $clog2(MAX_PORTS + 1);
  localparam int CNT_W     = $clog2(MAX_DEPTH + 1);
  localparam logic [SEL_W-1:0] SEL_ERR = {SEL_W{1'b1}};

  typedef logic [MAX_PORTS-1:0][31:0] addr_tbl_t;

  function automatic logic [SEL_W-1:0] dmem_decode(
    input logic [31:0] addr,
    input addr_tbl_t   mask,
    input addr_tbl_t   pattern,
    input int          num_ports,
    input int          default_port,
    input logic        default_en
  );
    logic [SEL_W-1:0] sel;
    logic             hit;
    sel = default_en ? SEL_W'(default_port) : SEL_ERR;
    hit = 1'b0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (!hit && (i < num_ports) && (i != default_port) && ((addr & mask[i]) == pattern[i])) begin
        sel = SEL_W'(i);
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/scr1_dmem_router_np_if.sv
// Core-side DMEM bus plus the fanned-out per-target buses of the router.
interface scr1_dmem_router_np_if
  import scr1_dmem_router_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic                                 dmem_req;
  logic                                 dmem_req_ack;
  type_scr1_mem_cmd_e                   dmem_cmd;
  type_scr1_mem_width_e                 dmem_width;
  logic [ADDR_W-1:0]                    dmem_addr;
  logic [DATA_W-1:0]                    dmem_wdata;
  logic [DATA_W-1:0]                    dmem_rdata;
  type_scr1_mem_resp_e                  dmem_resp;

  logic [NUM_PORTS-1:0]                 port_req;
  logic [NUM_PORTS-1:0]                 port_req_ack;
  type_scr1_mem_cmd_e   [NUM_PORTS-1:0] port_cmd;
  type_scr1_mem_width_e [NUM_PORTS-1:0] port_width;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]     port_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0]     port_wdata;
  logic [NUM_PORTS-1:0][DATA_W-1:0]     port_rdata;
  type_scr1_mem_resp_e  [NUM_PORTS-1:0] port_resp;

  modport master (
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp,
    input  port_req, port_cmd, port_width, port_addr, port_wdata,
    output port_req_ack, port_rdata, port_resp
  );

  modport slave (
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp,
    output port_req, port_cmd, port_width, port_addr, port_wdata,
    input  port_req_ack, port_rdata, port_resp
  );
endinterface

// File: rtl/scr1_dmem_router_np_chk.sv
// Simulation-only protocol checks for the DMEM router.
module scr1_dmem_router_np_chk
  import scr1_dmem_router_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_OUTST = 2
)(
  input logic                 clk,
  input logic                 rst,
  input logic                 i_req,
  input logic [SEL_W-1:0]     i_sel,
  input type_scr1_mem_cmd_e   i_cmd,
  input type_scr1_mem_width_e i_width,
  input logic [CNT_W-1:0]     i_count,
  input logic [NUM_PORTS-1:0] i_port_req
);
  a_req_known: assert property (@(posedge clk) disable iff (rst)
    i_req |-> !$isunknown({i_sel, i_cmd, i_width}));
  a_count_max: assert property (@(posedge clk) disable iff (rst)
    i_count <= CNT_W'(MAX_OUTST));
  a_req_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(i_port_req));
endmodule

// File: rtl/scr1_dmem_router_np_selq.sv
// In-order FIFO of target selects for outstanding requests; also tracks the tail select.
module scr1_dmem_router_selq
  import scr1_dmem_router_pkg::*;
#(
  parameter int DEPTH = 2
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [SEL_W-1:0] i_push_sel,
  input  logic             i_pop,
  output logic [SEL_W-1:0] o_head_sel,
  output logic [SEL_W-1:0] o_last_sel,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  logic [SEL_W-1:0] r_mem [MAX_DEPTH];
  logic [1:0]       r_wptr;
  logic [1:0]       r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [SEL_W-1:0] r_last_sel;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!o_full || w_do_pop);
  assign o_head_sel = r_mem[r_rptr];
  assign o_last_sel = r_last_sel;
  assign o_count    = r_count;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= 2'd0;
      r_rptr     <= 2'd0;
      r_count    <= '0;
      r_last_sel <= '0;
      for (int i = 0; i < MAX_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_push_sel;
        r_wptr        <= ptr_inc(r_wptr);
        r_last_sel    <= i_push_sel;
      end
      if (w_do_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/scr1_dmem_router_np.sv
// SCR1 DMEM router: decodes core requests onto NUM_PORTS targets with in-order,
// zero-latency request and response paths and an internal sink for unmapped addresses.
module scr1_dmem_router_np
  import scr1_dmem_router_pkg::*;
#(
  parameter int                          NUM_PORTS         = 4,
  parameter int                          ADDR_W            = 32,
  parameter int                          DATA_W            = 32,
  parameter int                          MAX_OUTST         = 2,
  parameter logic [NUM_PORTS-1:0][31:0]  PORT_ADDR_MASK    = {NUM_PORTS{32'hFFFF0000}},
  parameter logic [NUM_PORTS-1:0][31:0]  PORT_ADDR_PATTERN = {32'h00030000, 32'h00020000,
                                                              32'h00010000, 32'h00000000},
  parameter int                          DEFAULT_PORT      = 0,
  parameter bit                          DEFAULT_EN        = 1'b1
)(
  input  logic                 clk,
  input  logic                 rst,
  scr1_dmem_router_np_if.slave bus,
  output logic                 unmapped_err
);
  localparam addr_tbl_t L_MASK    = (MAX_PORTS * 32)'(PORT_ADDR_MASK);
  localparam addr_tbl_t L_PATTERN = (MAX_PORTS * 32)'(PORT_ADDR_PATTERN);

  logic [SEL_W-1:0]    w_sel;
  logic [SEL_W-1:0]    w_head_sel;
  logic [SEL_W-1:0]    w_last_sel;
  logic [CNT_W-1:0]    w_count;
  logic                w_full;
  logic                w_empty;
  type_scr1_mem_resp_e w_head_resp;
  logic [DATA_W-1:0]   w_head_rdata;
  logic                w_tgt_ack;
  logic                w_head_done;
  logic                w_allow;
  logic                w_issue;
  logic                w_push;
  logic                r_unmapped_err;

  assign w_sel = dmem_decode(32'(bus.dmem_addr), L_MASK, L_PATTERN,
                             NUM_PORTS, DEFAULT_PORT, DEFAULT_EN);

  scr1_dmem_router_selq #(.DEPTH(MAX_OUTST)) u_selq (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_sel (w_sel),
    .i_pop      (w_head_done),
    .o_head_sel (w_head_sel),
    .o_last_sel (w_last_sel),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Head response mux and accept of the decoded target; the error sink answers at head.
  always_comb begin
    w_head_resp  = SCR1_MEM_RESP_NOTRDY;
    w_head_rdata = '0;
    w_tgt_ack    = (w_sel == SEL_ERR);
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_head_resp  = (!w_empty && (w_head_sel == SEL_W'(i))) ? bus.port_resp[i]  : w_head_resp;
      w_head_rdata = (!w_empty && (w_head_sel == SEL_W'(i))) ? bus.port_rdata[i] : w_head_rdata;
      w_tgt_ack    = (w_sel == SEL_W'(i)) ? bus.port_req_ack[i] : w_tgt_ack;
    end
    w_head_resp = (!w_empty && (w_head_sel == SEL_ERR)) ? SCR1_MEM_RESP_RDY_ER : w_head_resp;
  end

  // A count of one whose head finishes now lets the core switch targets without a bubble.
  assign w_head_done = !w_empty && (w_head_resp != SCR1_MEM_RESP_NOTRDY);
  assign w_allow     = w_empty
                    || ((w_sel == w_last_sel) && (w_count < CNT_W'(MAX_OUTST)))
                    || ((w_count == CNT_W'(1)) && w_head_done);
  assign w_issue     = !rst && bus.dmem_req && w_allow;
  assign w_push      = w_issue && w_tgt_ack;

  assign bus.dmem_req_ack = w_push;
  assign bus.dmem_resp    = w_head_resp;
  assign bus.dmem_rdata   = w_head_rdata;

  // Per-port request strobes and request-field fan-out.
  always_comb begin
    bus.port_req   = '0;
    bus.port_addr  = '0;
    bus.port_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.port_req[i] = w_issue && (w_sel == SEL_W'(i));
`ifdef SCR1_XPROP_EN
      bus.port_cmd[i]   = (w_sel == SEL_W'(i)) ? bus.dmem_cmd   : SCR1_MEM_CMD_ERROR;
      bus.port_width[i] = (w_sel == SEL_W'(i)) ? bus.dmem_width : SCR1_MEM_WIDTH_ERROR;
      bus.port_addr[i]  = (w_sel == SEL_W'(i)) ? bus.dmem_addr  : {ADDR_W{1'bx}};
      bus.port_wdata[i] = (w_sel == SEL_W'(i)) ? bus.dmem_wdata : {DATA_W{1'bx}};
`else
      bus.port_cmd[i]   = bus.dmem_cmd;
      bus.port_width[i] = bus.dmem_width;
      bus.port_addr[i]  = bus.dmem_addr;
      bus.port_wdata[i] = bus.dmem_wdata;
`endif
    end
  end

  // Unmapped-access flag, visible the cycle after the sink accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_unmapped_err <= 1'b0;
    else     r_unmapped_err <= w_push && (w_sel == SEL_ERR);
  end

  assign unmapped_err = r_unmapped_err;

`ifndef SYNTHESIS
  scr1_dmem_router_np_chk #(.NUM_PORTS(NUM_PORTS), .MAX_OUTST(MAX_OUTST)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .i_req      (bus.dmem_req),
    .i_sel      (w_sel),
    .i_cmd      (bus.dmem_cmd),
    .i_width    (bus.dmem_width),
    .i_count    (w_count),
    .i_port_req (bus.port_req)
  );
`endif
endmodule

// File: tb/tb_scr1_dmem_router_np.sv
// Directed scoreboard bench for scr1_dmem_router_np: one DUT with default routing, one with the error sink.
module tb_scr1_dmem_router_np;
  import scr1_dmem_router_pkg::*;

  localparam int NP = 4;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err_a;
  logic err_b;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sbq[$];

  scr1_dmem_router_np_if #(.NUM_PORTS(NP)) bus_a ();
  scr1_dmem_router_np_if #(.NUM_PORTS(NP)) bus_b ();

  scr1_dmem_router_np #(.DEFAULT_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .unmapped_err(err_a));
  scr1_dmem_router_np #(.DEFAULT_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .unmapped_err(err_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input type_scr1_mem_resp_e r, input logic [31:0] d);
    sbq.push_back('{resp: 2'(r), rdata: d});
  endtask

  task automatic sb_pop(input string tag, input type_scr1_mem_resp_e r, input logic [31:0] d);
    exp_t e;
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed response %0h with empty scoreboard", tag, r);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".resp"},  64'(r), 64'(e.resp));
      chk({tag, ".rdata"}, 64'(d), 64'(e.rdata));
    end
  endtask

  task automatic idle_all();
    bus_a.dmem_req     = 1'b0;
    bus_b.dmem_req     = 1'b0;
    bus_a.port_req_ack = '0;
    bus_b.port_req_ack = '0;
    for (int i = 0; i < NP; i++) begin
      bus_a.port_resp[i]  = SCR1_MEM_RESP_NOTRDY;
      bus_b.port_resp[i]  = SCR1_MEM_RESP_NOTRDY;
      bus_a.port_rdata[i] = 32'h0;
      bus_b.port_rdata[i] = 32'h0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    idle_all();
  endtask

  task automatic drive_a(input logic [31:0] addr, input type_scr1_mem_cmd_e cmd);
    bus_a.dmem_req   = 1'b1;
    bus_a.dmem_cmd   = cmd;
    bus_a.dmem_width = SCR1_MEM_WIDTH_WORD;
    bus_a.dmem_addr  = addr;
    bus_a.dmem_wdata = ~addr;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, ".count"}, 64'(dut_a.w_count), 64'h0);
    chk({tag, ".resp"},  64'(bus_a.dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
  endtask

  initial begin
    bus_a.dmem_cmd = SCR1_MEM_CMD_RD; bus_a.dmem_width = SCR1_MEM_WIDTH_WORD;
    bus_a.dmem_addr = 32'h0; bus_a.dmem_wdata = 32'h0;
    bus_b.dmem_cmd = SCR1_MEM_CMD_RD; bus_b.dmem_width = SCR1_MEM_WIDTH_WORD;
    bus_b.dmem_addr = 32'h0; bus_b.dmem_wdata = 32'h0;
    idle_all();
    #1 rst = 1'b1;

    // reset: everything quiet even with a request and eager targets
    tick(); drive_a(32'h00020010, SCR1_MEM_CMD_RD); bus_a.port_req_ack = 4'b1111;
    for (int i = 0; i < NP; i++) bus_a.port_resp[i] = SCR1_MEM_RESP_RDY_OK;
    #1;
    chk("rst.ack",      64'(bus_a.dmem_req_ack), 64'h0);
    chk("rst.port_req", 64'(bus_a.port_req), 64'h0);
    chk("rst.rdata",    64'(bus_a.dmem_rdata), 64'h0);
    chk("rst.err",      64'(err_a), 64'h0);
    chk_idle_a("rst");
    tick(); rst = 1'b0;

    // t1: single read to port2
    tick(); drive_a(32'h00020010, SCR1_MEM_CMD_RD); bus_a.port_req_ack = 4'b0100; #1;
    chk("t1.port_req", 64'(bus_a.port_req), 64'h4);
    chk("t1.ack",      64'(bus_a.dmem_req_ack), 64'h1);
    chk("t1.fanout",   64'(bus_a.port_addr[1]), 64'h00020010);
    chk("t1.resp0",    64'(bus_a.dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
    sb_push(SCR1_MEM_RESP_RDY_OK, 32'hA5A5A5A5);
    tick(); bus_a.port_resp[2] = SCR1_MEM_RESP_RDY_OK; bus_a.port_rdata[2] = 32'hA5A5A5A5; #1;
    chk("t1.count1", 64'(dut_a.w_count), 64'h1);
    sb_pop("t1", bus_a.dmem_resp, bus_a.dmem_rdata);
    tick(); #1; chk_idle_a("t1.end");

    // t2: two back-to-back reads to port3, third stalls until first response
    tick(); drive_a(32'h00030000, SCR1_MEM_CMD_RD); bus_a.port_req_ack = 4'b1000; #1;
    chk("t2.ack0", 64'(bus_a.dmem_req_ack), 64'h1);
    chk("t2.port_req", 64'(bus_a.port_req), 64'h8);
    sb_push(SCR1_MEM_RESP_RDY_OK, 32'h11111111);
    tick(); drive_a(32'h00030004, SCR1_MEM_CMD_RD); bus_a.port_req_ack = 4'b1000; #1;
    chk("t2.ack1", 64'(bus_a.dmem_req_ack), 64'h1);
    sb_push(SCR1_MEM_RESP_RDY_OK, 32'h22222222);
    tick(); drive_a(32'h00030008, SCR1_MEM_CMD_RD); bus_a.port_req_ack = 4'b1000; #1;
    chk("t2.stall_ack", 64'(bus_a.dmem_req_ack), 64'h0);
    chk("t2.stall_preq", 64'(bus_a.port_req), 64'h0);
    chk("t2.count2", 64'(dut_a.w_count), 64'h2);
    tick(); drive_a(32'h00030008, SCR1_MEM_CMD_RD); bus_a.port_req_ack = 4'b1000;
    bus_a.port_resp[3] = SCR1_MEM_RESP_RDY_OK; bus_a.port_rdata[3] = 32'h11111111; #1;
    chk("t2.full_ack", 64'(bus_a.dmem_req_ack), 64'h0);
    sb_pop("t2.r0", bus_a.dmem_resp, bus_a.dmem_rdata);
    tick(); drive_a(32'h00030008, SCR1_MEM_CMD_RD); bus_a.port_req_ack = 4'b1000; #1;
    chk("t2.ack2", 64'(bus_a.dmem_req_ack), 64'h1);
    chk("t2.wait_resp", 64'(bus_a.dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
    sb_push(SCR1_MEM_RESP_RDY_OK, 32'h33333333);
    tick(); bus_a.port_resp[3] = SCR1_MEM_RESP_RDY_OK; bus_a.port_rdata[3] = 32'h22222222; #1;
    sb_pop("t2.r1", bus_a.dmem_resp, bus_a.dmem_rdata);
    tick(); bus_a.port_resp[3] = SCR1_MEM_RESP_RDY_OK; bus_a.port_rdata[3] = 32'h33333333; #1;
    sb_pop("t2.r2", bus_a.dmem_resp, bus_a.dmem_rdata);
    tick(); #1; chk_idle_a("t2.end");

    // t3: switch from port1 to port2 is held until port1 completes
    tick(); drive_a(32'h00010000, SCR1_MEM_CMD_RD); bus_a.port_req_ack = 4'b0010; #1;
    chk("t3.ack0", 64'(bus_a.dmem_req_ack), 64'h1);
    sb_push(SCR1_MEM_RESP_RDY_OK, 32'hB1B1B1B1);
    tick(); drive_a(32'h00020000, SCR1_MEM_CMD_RD); bus_a.port_req_ack = 4'b0100; #1;
    chk("t3.hold_ack", 64'(bus_a.dmem_req_ack), 64'h0);
    chk("t3.hold_preq", 64'(bus_a.port_req), 64'h0);
    tick(); drive_a(32'h00020000, SCR1_MEM_CMD_RD); bus_a.port_req_ack = 4'b0100;
    bus_a.port_resp[1] = SCR1_MEM_RESP_RDY_OK; bus_a.port_rdata[1] = 32'hB1B1B1B1; #1;
    chk("t3.sw_ack", 64'(bus_a.dmem_req_ack), 64'h1);
    chk("t3.sw_preq", 64'(bus_a.port_req), 64'h4);
    sb_pop("t3.r0", bus_a.dmem_resp, bus_a.dmem_rdata);
    sb_push(SCR1_MEM_RESP_RDY_OK, 32'hC2C2C2C2);
    tick(); bus_a.port_resp[2] = SCR1_MEM_RESP_RDY_OK; bus_a.port_rdata[2] = 32'hC2C2C2C2; #1;
    sb_pop("t3.r1", bus_a.dmem_resp, bus_a.dmem_rdata);
    tick(); #1; chk_idle_a("t3.end");

    // t5: unmapped read with default routing goes to port0, RDY_ER passes through
    tick(); drive_a(32'h00500000, SCR1_MEM_CMD_RD); bus_a.port_req_ack = 4'b0001; #1;
    chk("t5.port_req", 64'(bus_a.port_req), 64'h1);
    chk("t5.ack", 64'(bus_a.dmem_req_ack), 64'h1);
    sb_push(SCR1_MEM_RESP_RDY_ER, 32'hDEADBEEF);
    tick(); bus_a.port_resp[0] = SCR1_MEM_RESP_RDY_ER; bus_a.port_rdata[0] = 32'hDEADBEEF; #1;
    sb_pop("t5", bus_a.dmem_resp, bus_a.dmem_rdata);
    chk("t5.err", 64'(err_a), 64'h0);
    tick(); #1; chk_idle_a("t5.end");

    // t4: unmapped write into the error sink, port responses at that time are ignored
    tick();
    bus_b.dmem_req = 1'b1; bus_b.dmem_cmd = SCR1_MEM_CMD_WR; bus_b.dmem_width = SCR1_MEM_WIDTH_WORD;
    bus_b.dmem_addr = 32'h00500000; bus_b.dmem_wdata = 32'hCAFEF00D; #1;
    chk("t4.ack", 64'(bus_b.dmem_req_ack), 64'h1);
    chk("t4.port_req", 64'(bus_b.port_req), 64'h0);
    chk("t4.fanout", 64'(bus_b.port_wdata[3]), 64'hCAFEF00D);
    chk("t4.err0", 64'(err_b), 64'h0);
    sb_push(SCR1_MEM_RESP_RDY_ER, 32'h0);
    tick(); bus_b.port_resp[0] = SCR1_MEM_RESP_RDY_OK; bus_b.port_rdata[0] = 32'h12345678; #1;
    sb_pop("t4", bus_b.dmem_resp, bus_b.dmem_rdata);
    chk("t4.err1", 64'(err_b), 64'h1);
    tick(); #1;
    chk("t4.err2", 64'(err_b), 64'h0);
    chk("t4.idle", 64'(bus_b.dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));

    // t6: reset with two outstanding; late port3 response is dropped
    tick(); drive_a(32'h00030000, SCR1_MEM_CMD_RD); bus_a.port_req_ack = 4'b1000; #1;
    chk("t6.ack0", 64'(bus_a.dmem_req_ack), 64'h1);
    tick(); drive_a(32'h00030004, SCR1_MEM_CMD_RD); bus_a.port_req_ack = 4'b1000; #1;
    chk("t6.ack1", 64'(bus_a.dmem_req_ack), 64'h1);
    tick(); rst = 1'b1; #1;
    chk_idle_a("t6.rst");
    tick(); rst = 1'b0;
    bus_a.port_resp[3] = SCR1_MEM_RESP_RDY_OK; bus_a.port_rdata[3] = 32'h77777777; #1;
    chk_idle_a("t6.late");
    chk("t6.rdata", 64'(bus_a.dmem_rdata), 64'h0);
    tick(); #1; chk_idle_a("t6.end");

    chk("sb.drained", 64'(sbq.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
